// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 frame constants, receiver state enum and FIFO entry type
package ps2_pkg;

    localparam int FRAME_BITS = 11;
    localparam int START_IDX  = 0;
    localparam int PARITY_IDX = 9;
    localparam int STOP_IDX   = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } ps2_state_e;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } ps2_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word fall-through FIFO with exact occupancy count
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             wr_fire;
    logic             rd_fire;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    // a pop frees the head slot in the same edge, so a full FIFO can still take a write
    assign rd_fire = rd_en & ~empty;
    assign wr_fire = wr_en & (~full | rd_fire);
    // the head is forced to zero while empty so stale storage never shows on the outputs
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // occupancy follows the net effect of push and pop
    always_comb begin
        count_d = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // storage array is written only; no reset needed as contents are gated by empty
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver with clock filter, frame checker and output FIFO; PS2_RX_ERR_DROP_EN drops bad frames
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    input  logic                            rd_ready,
    output logic                            rd_valid,
    output logic [7:0]                      rd_data,
    output logic                            rd_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    output logic                            timeout
);

    localparam int FW = $clog2(FILTER_LEN+1);
    localparam int WW = $clog2(TIMEOUT_CYCLES+1);
    localparam int IW = $clog2(FRAME_BITS);
    localparam logic [IW-1:0] FIRST_BIT = IW'(START_IDX + 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(STOP_IDX);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_s;
    logic                   data_s;
    logic                   filt_q, filt_d, filt_prev_q;
    logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
    logic                   strobe;

    ps2_state_e             state_q, state_d;
    logic [IW-1:0]          bit_idx_q, bit_idx_d;
    logic [PARITY_IDX-1:0]  frame_q, frame_d;
    logic [WW-1:0]          wd_q, wd_d;
    logic                   push_req;
    logic                   push_wr;
    logic                   frame_err;
    logic                   timeout_d, timeout_q;
    logic                   overflow_d, overflow_q;

    ps2_entry_t             wr_entry;
    ps2_entry_t             head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // both pins pass through the same depth of synchroniser so their timing stays aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // filtered clock moves only after FILTER_LEN consecutive samples disagree with it
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    // filter state and previous value for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    assign strobe = filt_prev_q & ~filt_q;

    // frame FSM: start detection, LSB-first shift, stop check and mid-frame watchdog
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        wd_d      = wd_q;
        push_req  = 1'b0;
        timeout_d = 1'b0;
        // only meaningful in the stop-bit strobe: data plus parity must be odd, stop must be 1
        frame_err = ~(^frame_q) | ~data_s;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (strobe && !data_s) begin
                    state_d   = RECV;
                    bit_idx_d = FIRST_BIT;
                end
            end
            RECV: begin
                if (strobe) begin
                    wd_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d  = IDLE;
                        push_req = 1'b1;
                    end else begin
                        frame_d   = {data_s, frame_q[PARITY_IDX-1:1]};
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    wd_d      = '0;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM registers and the one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            frame_q    <= '0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef PS2_RX_ERR_DROP_EN
    assign push_wr = push_req & ~frame_err;
`else
    assign push_wr = push_req;
`endif

    assign wr_entry.err  = frame_err;
    assign wr_entry.data = frame_q[7:0];
    assign pop           = rd_valid & rd_ready;
    assign overflow_d    = push_wr & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH ($bits(ps2_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_wr),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rd_valid = ~fifo_empty;
    assign rd_data  = head.data;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;

`ifdef PS2_RX_ERR_DROP_EN
    logic unused_head_err;
    assign unused_head_err = head.err;
    assign rd_err = 1'b0;
`else
    assign rd_err = head.err;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - randomized bench for ps2_rx_fifo against a queue-based frame model
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int FLEN  = 4;
    localparam int TO    = 300;
    localparam int H     = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_err;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int ovf_seen = 0;
    int ovf_exp  = 0;
    int to_seen  = 0;
    int to_exp   = 0;
    int lat      = 0;
    logic [8:0] q[$];

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (2),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow) ovf_seen++;
        if (timeout)  to_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_cnt"}, fifo_count, q.size());
        check_eq({tag, "_valid"}, rd_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq({tag, "_data"}, rd_data, q[0][7:0]);
            check_eq({tag, "_err"}, rd_err, q[0][8]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, rd_valid, 0);
        check_eq({tag, "_data"}, rd_data, 0);
        check_eq({tag, "_err"}, rd_err, 0);
        check_eq({tag, "_cnt"}, fifo_count, 0);
        check_eq({tag, "_ovf"}, overflow, 0);
        check_eq({tag, "_to"}, timeout, 0);
    endtask

    // mode 0: plain bit; 1: measure push latency after the falling edge; 2: pop in the push cycle
    task automatic ps2_bit(input logic b, input int mode);
        ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 1; i <= H; i++) begin
            @(negedge clk);
            if (mode == 1 && lat == 0 && rd_valid) lat = i;
            if (mode == 2 && i == lat - 1) begin
                check_eq("coinc_head_valid", rd_valid, 1);
                check_eq("coinc_head_data", rd_data, q[0][7:0]);
                rd_ready = 1'b1;
            end
            if (mode == 2 && i == lat) begin
                rd_ready = 1'b0;
                void'(q.pop_front());
            end
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop, input int mode);
        logic p;
        logic err;
        p   = ~(^d) ^ par_flip;
        err = par_flip | ~stop;
        ps2_bit(1'b0, 0);
        for (int k = 0; k < 8; k++) ps2_bit(d[k], 0);
        ps2_bit(p, 0);
        ps2_bit(stop, mode);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
`ifdef PS2_RX_ERR_DROP_EN
        if (err) return;
`endif
        if (q.size() >= DEPTH) ovf_exp++;
        else q.push_back({err, d});
    endtask

    task automatic pop_one(input string tag);
        check_state(tag);
        if (q.size() != 0) begin
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            void'(q.pop_front());
        end else begin
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        while (q.size() != 0) pop_one(tag);
        check_state({tag, "_empty"});
    endtask

    initial begin
        int base;
        logic [7:0] b;
        logic [7:0] last_b;

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single good frame, head held while rd_ready low
        send_frame(8'h1C, 0, 1, 1);
        check_eq("calib_lat_found", lat != 0, 1);
        if (lat == 0) lat = 7;
        check_eq("f1c_data", rd_data, 8'h1C);
        check_eq("f1c_err", rd_err, 0);
        check_eq("f1c_cnt", fifo_count, 1);
        repeat (10) @(negedge clk);
        check_state("f1c_hold");
        pop_one("f1c_pop");
        check_eq("f1c_after_cnt", fifo_count, 0);
        check_eq("f1c_after_valid", rd_valid, 0);

        // parity error frame
        send_frame(8'hF0, 1, 1, 0);
`ifdef PS2_RX_ERR_DROP_EN
        check_eq("perr_dropped_cnt", fifo_count, 0);
`else
        check_eq("perr_data", rd_data, 8'hF0);
        check_eq("perr_err", rd_err, 1);
`endif
        drain("perr");

        // fill past full, expect one overflow and in-order read back
        base = ovf_seen;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 0);
        check_eq("full_cnt", fifo_count, DEPTH);
        check_eq("full_ovf_once", ovf_seen - base, 1);
        for (int i = 1; i <= 8; i++) check_eq("full_order", q[i-1][7:0], 8'(i));
        drain("full_read");

        // push coincident with pop while full
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 0, 1, 0);
        base = ovf_seen;
        last_b = 8'($urandom_range(0, 255));
        send_frame(last_b, 0, 1, 2);
        check_eq("coinc_no_ovf", ovf_seen - base, 0);
        check_eq("coinc_cnt", fifo_count, DEPTH);
        check_eq("coinc_tail", q[DEPTH-1][7:0], last_b);
        drain("coinc_read");

        // partial frame abandoned by the watchdog
        base = to_seen;
        ps2_bit(1'b0, 0);
        for (int k = 0; k < 3; k++) ps2_bit(1'($urandom_range(0, 1)), 0);
        ps2_data = 1'b1;
        repeat (TO + 60) @(negedge clk);
        to_exp++;
        check_eq("to_once", to_seen - base, 1);
        check_eq("to_cnt", fifo_count, 0);
        send_frame(8'h5A, 0, 1, 0);
        check_eq("after_to_data", rd_data, 8'h5A);
        drain("after_to");

        // short glitches and a bad start bit must not start a frame
        base = to_seen;
        for (int g = 0; g < 6; g++) begin
            ps2_data = 1'($urandom_range(0, 1));
            ps2_clk = 1'b0;
            repeat (FLEN - 1) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10 + $urandom_range(0, 10)) @(negedge clk);
        end
        ps2_bit(1'b1, 0);
        repeat (TO + 60) @(negedge clk);
        check_eq("glitch_cnt", fifo_count, 0);
        check_eq("glitch_no_to", to_seen - base, 0);
        send_frame(8'h33, 0, 1, 0);
        check_state("after_glitch");
        drain("after_glitch");

        // randomized traffic with occasional errors and reads
        for (int n = 0; n < 36; n++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0, 0);
            check_state("rnd");
            for (int r = $urandom_range(0, 2); r > 0; r--) pop_one("rnd_pop");
        end
        drain("rnd_drain");

        // reset with a buffered entry and a frame in flight
        send_frame(8'hA5, 0, 1, 0);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("post_rst");
        send_frame(8'h77, 0, 1, 0);
        check_state("post_rst_frame");
        drain("post_rst");

        check_eq("ovf_total", ovf_seen, ovf_exp);
        check_eq("to_total", to_seen, to_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
